hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised RAW/WAW hazard detector for the decode stage. It keeps a per-register pending-write scoreboard, set when a writing instruction issues and cleared by any of several writeback ports, so multi-cycle ALU, memory and other units can complete out of order. It drives a combinational `stall` to decode, a saturating stall-cycle performance counter and a sticky deadlock flag. It sits between decode and the issue/writeback network.

## Interface
Parameters:
- `NUM_REGS`, 32, architectural registers; register 0 is hard-wired zero.
- `REG_IDX_W`, 5, register index width; must satisfy 2^REG_IDX_W >= NUM_REGS.
- `NUM_SRC`, 2, source operands checked per decoded instruction.
- `NUM_WB`, 2, writeback ports (e.g. ALU, memory).
- `TIMEOUT`, 1024, consecutive stall cycles before `deadlock` is raised; minimum 1.

Ports:
- `clk` in 1, single clock, rising edge.
- `rst` in 1, reset, asynchronous, active-high.
- `dec_valid` in 1, decode holds a valid instruction.
- `dec_src_idx` in NUM_SRC*REG_IDX_W, source indices, packed; src k at bits [k*REG_IDX_W +: REG_IDX_W].
- `dec_src_used` in NUM_SRC, per-source read enable.
- `dec_dst_idx` in REG_IDX_W, destination index.
- `dec_dst_we` in 1, instruction writes `dec_dst_idx`.
- `wb_valid` in NUM_WB, per-port writeback strobe.
- `wb_idx` in NUM_WB*REG_IDX_W, writeback indices, packed like `dec_src_idx`.
- `flush` in 1, squash: clears all pending bits.
- `stall` out 1, decode must hold.
- `pending` out NUM_REGS, current scoreboard, for debug.
- `stall_cycles` out 32, saturating count of cycles with `stall`=1.
- `deadlock` out 1, sticky watchdog flag.

## Operation
- Scoreboard: `pending[NUM_REGS-1:0]` register. Bit 0 is constant 0.
- Issue: `issue = dec_valid & ~stall`. When `issue & dec_dst_we & dec_dst_idx!=0`, set the `pending` bit of `dec_dst_idx`.
- Clear: each `wb_valid[p]` clears the bit of `wb_idx[p]`. A writeback to a register that is not pending has no effect. Several ports hitting the same index are legal.
- Same-cycle set and clear on one index: set wins.
- RAW: stall when any k has `dec_src_used[k]`, `src_k!=0` and `pending[src_k]`=1 (subject to Configuration).
- WAW: stall when `dec_dst_we`, `dst!=0` and `pending[dst]`=1 (subject to Configuration).
- `stall` is forced to 0 when `dec_valid`=0 or `flush`=1.
- Flush: next `pending` = all 0, and issue is suppressed that cycle. Squashed producers must never assert `wb_valid` afterwards.
- Indices >= NUM_REGS are ignored for set, clear and check.
- `stall_cycles`: increments every cycle `stall`=1 and saturates at 0xFFFF_FFFF.
- Watchdog (sub-module): run counter increments while `stall`=1 and resets to 0 when `stall`=0. When the counter reaches TIMEOUT, `deadlock` is set and stays set until reset.

## Timing
- `stall` is combinational from `pending` and the current-cycle inputs, so it is valid in the same cycle.
- A set or clear in cycle N is visible in `pending` in cycle N+1.
- Back-to-back dependent instructions therefore stall at least one cycle.
- Reset values: `pending`=0, `stall_cycles`=0, `deadlock`=0, watchdog counter 0. `stall`=0 follows from `pending`=0.
- Reset mid-operation clears all state immediately. In-flight writebacks after reset are ignored because their bits are already clear.
- `deadlock` rises in the cycle after the TIMEOUT-th consecutive stall cycle.

## Configuration
- `SCOREBOARD_WB_BYPASS_EN` defined: a register being cleared by `wb_valid` in the current cycle counts as not pending for the RAW and WAW checks. This relies on the write-through register file. Dependent instructions issue in the writeback cycle.
- Undefined: checks use registered `pending` only, which costs one extra stall cycle per dependency.

## Structure
- Shared constants go in `src/parameters.v` (register count, index width, default TIMEOUT), with a display macro `HAZARD_SCOREBOARD_DISPLAY` following the existing display-macro scheme.
- Sub-module: `stall_watchdog` (parameter TIMEOUT; ports clk, rst, stall in; deadlock out). It holds the run counter, sized $clog2(TIMEOUT+1), and the sticky flag.

## Test plan
- Issue dst=x5 in cycle 0; cycle 1 decode src1=x5 -> `stall`=1 until `wb_valid[0]`, `wb_idx`=5. Bypass on: `stall`=0 in the wb cycle. Bypass off: `stall`=0 one cycle later.
- Decode dst=x0 then src=x0 -> `pending`=0 and `stall`=0 throughout.
- x3 pending; decode dst=x3, no sources used -> WAW `stall`=1. `wb_valid[1]`, idx 3 -> `stall` clears per the bypass setting.
- x7 and x9 pending; both wb ports write back 7 and 9 in the same cycle -> `pending`=0 next cycle.
- Same-cycle issue dst=x4 and wb idx 4 (bypass on, x4 pending) -> x4 stays pending.
- TIMEOUT=4, hold a RAW stall for 4 cycles -> `deadlock`=1 in cycle 5 and `stall_cycles`=4. Flush -> `stall`=0 and `deadlock` stays 1 until `rst`.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared defaults and helpers for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int DEFAULT_NUM_REGS  = 32;
    localparam int DEFAULT_REG_IDX_W = 5;
    localparam int DEFAULT_NUM_SRC   = 2;
    localparam int DEFAULT_NUM_WB    = 2;
    localparam int DEFAULT_TIMEOUT   = 1024;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - counts consecutive stall cycles and latches a sticky deadlock flag
module stall_watchdog
    import hazard_scoreboard_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic deadlock
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] run_q, run_d;
    logic             dl_q, dl_d;

    // Counter saturates at TIMEOUT; the flag fires on the TIMEOUT-th stall edge.
    always_comb begin
        run_d = run_q;
        if (!stall) begin
            run_d = '0;
        end else if (run_q != CNT_W'(TIMEOUT)) begin
            run_d = run_q + CNT_W'(1);
        end
        dl_d = dl_q | (stall && (run_q == CNT_W'(TIMEOUT - 1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
            dl_q  <= 1'b0;
        end else begin
            run_q <= run_d;
            dl_q  <= dl_d;
        end
    end

    assign deadlock = dl_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW/WAW pending-write scoreboard; SCOREBOARD_WB_BYPASS_EN lets same-cycle writebacks unblock decode
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int REG_IDX_W = DEFAULT_REG_IDX_W,
    parameter int NUM_SRC   = DEFAULT_NUM_SRC,
    parameter int NUM_WB    = DEFAULT_NUM_WB,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           dec_valid,
    input  logic [NUM_SRC*REG_IDX_W-1:0]   dec_src_idx,
    input  logic [NUM_SRC-1:0]             dec_src_used,
    input  logic [REG_IDX_W-1:0]           dec_dst_idx,
    input  logic                           dec_dst_we,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*REG_IDX_W-1:0]    wb_idx,
    input  logic                           flush,
    output logic                           stall,
    output logic [NUM_REGS-1:0]            pending,
    output logic [31:0]                    stall_cycles,
    output logic                           deadlock
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] clr_mask, set_mask, check_mask;
    logic [31:0]         stall_cycles_q, stall_cycles_d;
    logic                hazard;
    logic                stall_c;

    // Index decodes skip register 0 and anything >= NUM_REGS, so those never set, clear or match.
    always_comb begin
        clr_mask = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wb_valid[p] && (wb_idx[p*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r))) begin
                    clr_mask[r] = 1'b1;
                end
            end
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign check_mask = pending_q & ~clr_mask;
`else
    assign check_mask = pending_q;
`endif

    always_comb begin
        hazard = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (dec_src_used[k] && (dec_src_idx[k*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r))
                        && check_mask[r]) begin
                    hazard = 1'b1;
                end
            end
            if (dec_dst_we && (dec_dst_idx == REG_IDX_W'(r)) && check_mask[r]) begin
                hazard = 1'b1;
            end
        end
    end

    assign stall_c = dec_valid & ~flush & hazard;

    // Set is applied after clear so a same-cycle issue keeps its bit.
    always_comb begin
        set_mask = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (dec_valid && !stall_c && !flush && dec_dst_we && (dec_dst_idx == REG_IDX_W'(r))) begin
                set_mask[r] = 1'b1;
            end
        end
        if (flush) begin
            pending_d = '0;
        end else begin
            pending_d = (pending_q & ~clr_mask) | set_mask;
        end
        pending_d[0] = 1'b0;
        stall_cycles_d = stall_c ? sat_inc32(stall_cycles_q) : stall_cycles_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            pending_q      <= pending_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    stall_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall_c),
        .deadlock (deadlock)
    );

    assign stall        = stall_c;
    assign pending      = pending_q;
    assign stall_cycles = stall_cycles_q;

endmodule
